duck_sprite_render: RTL and testbench

Pixel-pipeline stage directly downstream of the duck sprite frame RAMs (up / middle / down poses, 20x20, one palette index per word). It turns the current VGA draw coordinate and duck position into a RAM read address, absorbs the RAM's one-cycle registered read, and selects the pose through a wing-flap animation state machine. It emits a registered palette index plus an opaque flag to the colour mapper.

---
 rtl/duck_pkg.sv | 23 ++
 rtl/duck_sprite_render_if.sv | 31 +++
 rtl/duck_anim_fsm.sv | 53 +++++
 rtl/duck_sprite_render.sv | 102 ++++++++++
 tb/tb_duck_sprite_render.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/duck_pkg.sv
// Shared types and defaults for the duck sprite render path.
// Used by duck_anim_fsm and duck_sprite_render.
package duck_pkg;

    typedef enum logic [1:0] {UP, MID_DN, DOWN, MID_UP} anim_state_t;
    typedef enum logic [1:0] {POSE_UP, POSE_MID, POSE_DOWN} pose_sel_t;

    localparam logic [2:0] TRANSPARENT_IDX = 3'd0;
    localparam int DEF_SPRITE_W = 20;
    localparam int DEF_SPRITE_H = 20;

    // Both mid-wing states share the middle frame RAM.
    function automatic pose_sel_t state_to_pose(input anim_state_t s);
        pose_sel_t p;
        case (s)
            UP:      p = POSE_UP;
            DOWN:    p = POSE_DOWN;
            default: p = POSE_MID;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/duck_sprite_render_if.sv
// Pixel/RAM signal bundle between the VGA side, the pose RAMs and the renderer.
// master = environment (VGA timing, game logic, RAMs); slave = renderer.
interface duck_sprite_render_if #(
    parameter int ADDR_W = 19
);
    logic              frame_tick;
    logic              anim_en;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [9:0]        duck_x;
    logic [9:0]        duck_y;
    logic              duck_dir;
    logic [ADDR_W-1:0] read_address;
    logic [4:0]        ram_up;
    logic [4:0]        ram_mid;
    logic [4:0]        ram_down;
    logic [2:0]        pixel_idx;
    logic              pixel_on;

    modport master (
        output frame_tick, anim_en, DrawX, DrawY, duck_x, duck_y, duck_dir,
        output ram_up, ram_mid, ram_down,
        input  read_address, pixel_idx, pixel_on
    );

    modport slave (
        input  frame_tick, anim_en, DrawX, DrawY, duck_x, duck_y, duck_dir,
        input  ram_up, ram_mid, ram_down,
        output read_address, pixel_idx, pixel_on
    );
endinterface

// File: rtl/duck_anim_fsm.sv
// Wing-flap animation: frame_tick divider plus UP/MID_DN/DOWN/MID_UP cycle.
// Advances one pose every FRAME_DIV enabled ticks; anim_en = 0 freezes both.
module duck_anim_fsm
    import duck_pkg::*;
#(
    parameter int FRAME_DIV = 6
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_frame_tick,
    input  logic      i_anim_en,
    output pose_sel_t o_pose
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    anim_state_t      r_state;
    anim_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= UP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_frame_tick && i_anim_en) begin
            if (r_cnt == CNT_LAST) begin
                w_cnt_nxt = '0;
                case (r_state)
                    UP:      w_state_nxt = MID_DN;
                    MID_DN:  w_state_nxt = DOWN;
                    DOWN:    w_state_nxt = MID_UP;
                    MID_UP:  w_state_nxt = UP;
                    default: w_state_nxt = UP;
                endcase
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
        o_pose = state_to_pose(r_state);
    end

endmodule

// File: rtl/duck_sprite_render.sv
// Duck sprite pixel pipeline: hit test + RAM address, 1-cycle RAM read, pose mux.
// `define DUCK_MIRROR_EN to draw a left-facing duck (duck_dir = 1) mirrored.
module duck_sprite_render
    import duck_pkg::*;
#(
    parameter int SPRITE_W  = DEF_SPRITE_W,
    parameter int SPRITE_H  = DEF_SPRITE_H,
    parameter int FRAME_DIV = 6,
    parameter int ADDR_W    = 19
) (
    input logic                  Clk,
    input logic                  Reset_n,
    duck_sprite_render_if.slave  bus
);

    pose_sel_t          w_pose;
    logic signed [10:0] w_dx;
    logic signed [10:0] w_dy;
    logic               w_hit;
    logic [9:0]         w_dx_eff;
    logic [ADDR_W-1:0]  w_addr;
    logic [2:0]         w_ram_idx;
    logic               w_opaque;

    logic [ADDR_W-1:0]  r_read_address;
    logic               r_hit_d1;
    logic               r_hit_d2;
    pose_sel_t          r_sel_d1;
    pose_sel_t          r_sel_d2;
    logic [2:0]         r_pixel_idx;
    logic               r_pixel_on;

    duck_anim_fsm #(.FRAME_DIV(FRAME_DIV)) u_anim (
        .i_clk        (Clk),
        .i_rst_n      (Reset_n),
        .i_frame_tick (bus.frame_tick),
        .i_anim_en    (bus.anim_en),
        .o_pose       (w_pose)
    );

    // Stage 0: signed offsets so a duck near the right edge never wraps onto column 0.
    assign w_dx  = $signed({1'b0, bus.DrawX}) - $signed({1'b0, bus.duck_x});
    assign w_dy  = $signed({1'b0, bus.DrawY}) - $signed({1'b0, bus.duck_y});
    assign w_hit = !w_dx[10] && !w_dy[10]
                && (w_dx[9:0] < 10'(SPRITE_W)) && (w_dy[9:0] < 10'(SPRITE_H));

`ifdef DUCK_MIRROR_EN
    assign w_dx_eff = bus.duck_dir ? (10'(SPRITE_W - 1) - w_dx[9:0]) : w_dx[9:0];
    wire w_unused_ok = ^{bus.ram_up[4:3], bus.ram_mid[4:3], bus.ram_down[4:3]};
`else
    assign w_dx_eff = w_dx[9:0];
    wire w_unused_ok = ^{bus.duck_dir, bus.ram_up[4:3], bus.ram_mid[4:3], bus.ram_down[4:3]};
`endif

    assign w_addr = w_hit ? (ADDR_W'(w_dy[9:0]) * ADDR_W'(SPRITE_W) + ADDR_W'(w_dx_eff))
                          : '0;

    // Stage 1 (address to RAM) and stage 2 (RAM data valid): hit/pose ride along.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_read_address <= '0;
            r_hit_d1       <= 1'b0;
            r_sel_d1       <= POSE_UP;
            r_hit_d2       <= 1'b0;
            r_sel_d2       <= POSE_UP;
        end else begin
            r_read_address <= w_addr;
            r_hit_d1       <= w_hit;
            r_sel_d1       <= w_pose;
            r_hit_d2       <= r_hit_d1;
            r_sel_d2       <= r_sel_d1;
        end
    end

    always_comb begin
        w_ram_idx = TRANSPARENT_IDX;
        case (r_sel_d2)
            POSE_UP:   w_ram_idx = bus.ram_up[2:0];
            POSE_MID:  w_ram_idx = bus.ram_mid[2:0];
            POSE_DOWN: w_ram_idx = bus.ram_down[2:0];
            default:   w_ram_idx = TRANSPARENT_IDX;
        endcase
    end

    assign w_opaque = r_hit_d2 && (w_ram_idx != TRANSPARENT_IDX);

    // Stage 3: registered output to the colour mapper.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pixel_on  <= 1'b0;
            r_pixel_idx <= TRANSPARENT_IDX;
        end else begin
            r_pixel_on  <= w_opaque;
            r_pixel_idx <= w_opaque ? w_ram_idx : TRANSPARENT_IDX;
        end
    end

    assign bus.read_address = r_read_address;
    assign bus.pixel_on     = r_pixel_on;
    assign bus.pixel_idx    = r_pixel_idx;

endmodule

// File: tb/tb_duck_sprite_render.sv
// Bench for duck_sprite_render: emulated pose RAMs, tick-count pose model,
// per-cycle comparison of address and pixel outputs plus directed literal checks.
module tb_duck_sprite_render;

    localparam int W     = 20;
    localparam int H     = 20;
    localparam int FD    = 6;
    localparam int AW    = 19;
    localparam int NHIST = 8192;
`ifdef DUCK_MIRROR_EN
    localparam bit MIRROR = 1'b1;
`else
    localparam bit MIRROR = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    duck_sprite_render_if #(.ADDR_W(AW)) bus();

    duck_sprite_render #(
        .SPRITE_W(W), .SPRITE_H(H), .FRAME_DIV(FD), .ADDR_W(AW)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    logic [4:0] mem_up  [W*H];
    logic [4:0] mem_mid [W*H];
    logic [4:0] mem_dn  [W*H];

    // Registered-read frame RAMs.
    always @(posedge Clk) begin : ram_model
        int a;
        a = int'(bus.read_address);
        bus.ram_up   <= (a < W*H) ? mem_up[a]  : 5'h00;
        bus.ram_mid  <= (a < W*H) ? mem_mid[a] : 5'h00;
        bus.ram_down <= (a < W*H) ? mem_dn[a]  : 5'h00;
    end

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int en_ticks = 0;
    int exp_addr [NHIST];
    int exp_on   [NHIST];
    int exp_idx  [NHIST];

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, expv, $time);
    endtask

    // 0 = up RAM, 1 = mid RAM, 2 = down RAM, from the number of enabled ticks seen.
    function automatic int pose_now();
        int s;
        s = (en_ticks / FD) % 4;
        if (s == 0) return 0;
        if (s == 2) return 2;
        return 1;
    endfunction

    function automatic int mem_rd(input int pose, input int a);
        if (pose == 0) return int'(mem_up[a][2:0]);
        if (pose == 1) return int'(mem_mid[a][2:0]);
        return int'(mem_dn[a][2:0]);
    endfunction

    // One clock of stimulus; records what the outputs for this coordinate must be.
    task automatic step(input int x, input int y, input int px, input int py,
                        input bit dir, input bit tick, input bit en, input bit rn);
        int dx, dy, dxe, a, slot, idx;
        bit hit;
        @(negedge Clk);
        Reset_n        = rn;
        bus.DrawX      = 10'(x);
        bus.DrawY      = 10'(y);
        bus.duck_x     = 10'(px);
        bus.duck_y     = 10'(py);
        bus.duck_dir   = dir;
        bus.frame_tick = tick;
        bus.anim_en    = en;
        slot = cyc % NHIST;
        if (!rn) begin
            for (int k = 0; k <= 2; k++) begin
                if (cyc - k >= 0) begin
                    exp_addr[(cyc - k) % NHIST] = 0;
                    exp_on[(cyc - k) % NHIST]   = 0;
                    exp_idx[(cyc - k) % NHIST]  = 0;
                end
            end
            en_ticks = 0;
        end else begin
            dx  = (x & 1023) - (px & 1023);
            dy  = (y & 1023) - (py & 1023);
            hit = (dx >= 0) && (dy >= 0) && (dx < W) && (dy < H);
            dxe = (MIRROR && dir) ? (W - 1 - dx) : dx;
            a   = hit ? dy * W + dxe : 0;
            idx = mem_rd(pose_now(), a);
            exp_addr[slot] = a;
            exp_on[slot]   = (hit && idx != 0) ? 1 : 0;
            exp_idx[slot]  = (hit && idx != 0) ? idx : 0;
            if (tick && en) en_ticks++;
        end
        cyc++;
    endtask

    // Per-cycle comparison against the model history.
    always @(posedge Clk) begin
        #1;
        if (cyc >= 1)
            chk("read_address", int'(bus.read_address), exp_addr[(cyc - 1) % NHIST]);
        if (cyc >= 3) begin
            chk("pixel_on", int'(bus.pixel_on), exp_on[(cyc - 3) % NHIST]);
            chk("pixel_idx", int'(bus.pixel_idx), exp_idx[(cyc - 3) % NHIST]);
        end
    end

    task automatic tick_n(input int n, input bit en);
        repeat (n) begin
            step(0, 0, 200, 100, 1'b0, 1'b1, en, 1'b1);
            step(0, 0, 200, 100, 1'b0, 1'b0, en, 1'b1);
        end
    endtask

    task automatic probe_pose(input string name, input int expv);
        step(200, 100, 200, 100, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) step(0, 0, 200, 100, 1'b0, 1'b0, 1'b1, 1'b1);
        chk(name, int'(bus.pixel_idx), expv);
    endtask

    initial begin
        for (int i = 0; i < W*H; i++) begin
            mem_up[i]  = 5'($urandom);
            mem_mid[i] = 5'($urandom);
            mem_dn[i]  = 5'($urandom);
        end
        mem_up[0]  = 5'h01;
        mem_mid[0] = 5'h02;
        mem_dn[0]  = 5'h03;
        mem_up[45] = 5'h03;
        mem_up[46] = 5'h18;
        bus.frame_tick = 1'b0; bus.anim_en = 1'b0;
        bus.DrawX = '0; bus.DrawY = '0; bus.duck_x = '0; bus.duck_y = '0; bus.duck_dir = 1'b0;

        repeat (3) step(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Address, latency, miss and transparency at duck (100,50).
        step(105, 52, 100, 50, 1'b0, 1'b0, 1'b1, 1'b1);
        step(106, 52, 100, 50, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("addr_105_52", int'(bus.read_address), 45);
        step(99, 52, 100, 50, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("addr_106_52", int'(bus.read_address), 46);
        step(105, 52, 100, 50, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("addr_miss", int'(bus.read_address), 0);
        chk("hit_pixel_on", int'(bus.pixel_on), 1);
        chk("hit_pixel_idx", int'(bus.pixel_idx), 3);
        step(105, 52, 100, 50, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("transp_on", int'(bus.pixel_on), 0);
        chk("transp_idx", int'(bus.pixel_idx), 0);
        step(105, 52, 100, 50, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("miss_on", int'(bus.pixel_on), 0);

        // Asynchronous reset with hits in flight.
        step(105, 52, 100, 50, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("rst_addr", int'(bus.read_address), 0);
        chk("rst_on", int'(bus.pixel_on), 0);
        chk("rst_idx", int'(bus.pixel_idx), 0);
        repeat (2) step(105, 52, 100, 50, 1'b0, 1'b0, 1'b1, 1'b0);
        probe_pose("pose_after_reset", 1);

        // Animation sequence and freeze.
        tick_n(6, 1'b1);  probe_pose("pose_tick6", 2);
        tick_n(6, 1'b1);  probe_pose("pose_tick12", 3);
        tick_n(6, 1'b1);  probe_pose("pose_tick18", 2);
        tick_n(6, 1'b1);  probe_pose("pose_tick24", 1);
        tick_n(8, 1'b1);
        tick_n(10, 1'b0); probe_pose("pose_frozen", 2);
        tick_n(4, 1'b1);  probe_pose("pose_resumed", 3);

        // Right-edge clip at duck_x = 630.
        for (int xx = 625; xx < 640; xx++) step(xx, 305, 630, 300, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int xx = 0; xx < 10; xx++) step(xx, 305, 630, 300, 1'b0, 1'b0, 1'b1, 1'b1);
        step(639, 300, 630, 300, 1'b0, 1'b0, 1'b1, 1'b1);
        step(5, 300, 630, 300, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("edge_addr_639", int'(bus.read_address), 9);
        step(0, 0, 630, 300, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("edge_addr_wrap", int'(bus.read_address), 0);

        // Mirroring at the sprite origin.
        step(200, 100, 200, 100, 1'b1, 1'b0, 1'b1, 1'b1);
        step(0, 0, 200, 100, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("mirror_addr", int'(bus.read_address), MIRROR ? 19 : 0);

        // Randomized traffic around the duck.
        for (int n = 0; n < 2000; n++) begin
            int px, py;
            px = int'($urandom_range(0, 639));
            py = int'($urandom_range(0, 479));
            step(px + int'($urandom_range(0, 27)) - 4,
                 py + int'($urandom_range(0, 27)) - 4,
                 px, py, 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 499) != 0));
        end
        repeat (4) step(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);

        @(negedge Clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
